htif_mailbox: RTL and testbench

- Target-side tohost/fromhost mailbox. It is the writer end of the tohost channel that the simulation host polls, and the reader end of the fromhost channel.
- The core reaches it through a simple single-outstanding request/response port. The host side sees a 64-bit tohost level, a consume pulse, and a fromhost write channel.
- Sits in the SoC next to the memory-mapped peripherals. Its tohost output drives the testbench pass/fail and fuzz-round logic.

---
 rtl/htif_mailbox.sv | 93 +++++++++
 tb/tb_htif_mailbox.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/htif_mailbox.sv
// htif_mailbox: target-side tohost/fromhost mailbox with a single-outstanding core port
module htif_mailbox #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] TOHOST_OFF = 12'h000,
  parameter logic [ADDR_W-1:0] FROMHOST_OFF = 12'h008,
  parameter logic [ADDR_W-1:0] STATUS_OFF = 12'h010
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [63:0]       tohost,
  output logic              tohost_valid,
  input  logic              host_ack,
  input  logic              fromhost_wvalid,
  input  logic [63:0]       fromhost_wdata,
  output logic              fromhost_wready,
  output logic              fromhost_busy
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic [63:0] tohost_q, tohost_d, fromhost_q, fromhost_d, rdata_q, rdata_d;
  logic [15:0] overrun_q, overrun_d;
  logic        err_q, err_d;
  logic [63:0] wmask, status, rd_val;
  logic        accept, hit_to, hit_from, hit_stat, dec_err, wr_to, wr_from;
  for (genvar b = 0; b < 8; b++) begin : g_mask
    assign wmask[8*b+:8] = {8{req_wstrb[b]}};
  end
  assign req_ready       = state_q == IDLE;
  assign resp_valid      = state_q == RESP;
  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign tohost          = tohost_q;
  assign tohost_valid    = tohost_q != '0;
  assign fromhost_busy   = fromhost_q != '0;
  assign accept          = req_valid && req_ready;
  assign hit_to          = req_addr == TOHOST_OFF;
  assign hit_from        = req_addr == FROMHOST_OFF;
  assign hit_stat        = req_addr == STATUS_OFF;
  assign dec_err         = req_addr[2:0] != 3'd0 || !(hit_to || hit_from || hit_stat) || (req_write && hit_stat);
  assign wr_to           = accept && req_write && hit_to && !dec_err;
  assign wr_from         = accept && req_write && hit_from && !dec_err;
  assign fromhost_wready = !fromhost_busy && !wr_from;
  assign status          = {46'd0, fromhost_busy, tohost_valid, overrun_q};
  assign rd_val          = hit_to ? tohost_q : hit_from ? fromhost_q : status;
  // Request/response handshake: capture the response at accept, hold it until taken
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = RESP;
      err_d   = dec_err;
      rdata_d = (dec_err || req_write) ? 64'd0 : rd_val;
    end else if (resp_valid && resp_ready) begin
      state_d = IDLE;
    end
  end
  // Mailbox registers: core writes win over host ack / host write in the same cycle
  always_comb begin
    tohost_d   = wr_to ? (tohost_q & ~wmask) | (req_wdata & wmask) : host_ack ? 64'd0 : tohost_q;
    overrun_d  = (wr_to && tohost_valid && overrun_q != 16'hFFFF) ? overrun_q + 16'd1 : overrun_q;
    fromhost_d = wr_from ? (fromhost_q & ~wmask) | (req_wdata & wmask) :
                 (fromhost_wvalid && fromhost_wready) ? fromhost_wdata : fromhost_q;
  end
  // State and register update with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tohost_q   <= '0;
      fromhost_q <= '0;
      overrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      overrun_q  <= overrun_d;
    end
  end
endmodule

// File: tb/tb_htif_mailbox.sv
// tb_htif_mailbox: scoreboard bench for the tohost/fromhost mailbox
module tb_htif_mailbox;
  localparam logic [11:0] TO = 12'h000, FROM = 12'h008, STAT = 12'h010;
  logic        clock = 0, reset = 0;
  logic        req_valid = 0, req_write = 0, resp_ready = 1, host_ack = 0, fromhost_wvalid = 0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_wdata = '0, fromhost_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err, tohost_valid, fromhost_wready, fromhost_busy;
  logic [63:0] resp_rdata, tohost;
  int          checks = 0, errors = 0;
  logic [64:0] exp_q[$];
  htif_mailbox dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tohost(tohost), .tohost_valid(tohost_valid), .host_ack(host_ack),
    .fromhost_wvalid(fromhost_wvalid), .fromhost_wdata(fromhost_wdata),
    .fromhost_wready(fromhost_wready), .fromhost_busy(fromhost_busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Response monitor: every handshake pops the oldest expected {err, rdata}
  always @(negedge clock) begin
    if (reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("resp_err", {63'd0, resp_err}, {63'd0, e[64]});
        chk("resp_rdata", resp_rdata, e[63:0]);
      end
    end
  end
  task automatic core_req(input logic w, input logic [11:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic e, input logic [63:0] r);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    exp_q.push_back({e, r});
    tick();
    req_valid = 0; host_ack = 0; fromhost_wvalid = 0;
    chk("latency", {63'd0, resp_valid}, 64'd1);
    tick();
  endtask
  initial begin
    repeat (2) tick();
    reset = 1;
    tick();
    // Dirty the registers, then reset while a response is pending
    core_req(1, TO, 64'h7, 8'hFF, 0, 0);
    core_req(1, TO, 64'h9, 8'hFF, 0, 0);
    chk("pre_reset_tohost", tohost, 64'h9);
    resp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = STAT;
    tick();
    req_valid = 0;
    chk("pending_resp", {63'd0, resp_valid}, 64'd1);
    reset = 0;
    repeat (3) tick();
    reset = 1;
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_tohost", tohost, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    resp_ready = 1;
    core_req(0, STAT, 0, 0, 0, 64'd0);
    // Basic tohost write and host consume
    core_req(1, TO, 64'h1, 8'hFF, 0, 0);
    chk("tohost_1", tohost, 64'h1);
    chk("tohost_valid", {63'd0, tohost_valid}, 64'd1);
    host_ack = 1;
    tick();
    host_ack = 0;
    chk("tohost_acked", tohost, 64'd0);
    // Overrun and write-beats-ack
    core_req(1, TO, 64'h3, 8'hFF, 0, 0);
    core_req(1, TO, 64'h5, 8'hFF, 0, 0);
    chk("tohost_5", tohost, 64'h5);
    core_req(0, STAT, 0, 0, 0, 64'h1_0001);
    host_ack = 1;
    core_req(1, TO, 64'h5, 8'hFF, 0, 0);
    chk("write_beats_ack", tohost, 64'h5);
    host_ack = 1;
    tick();
    host_ack = 0;
    // Byte merge
    core_req(1, TO, 64'h1122334455667788, 8'hFF, 0, 0);
    core_req(1, TO, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0);
    core_req(0, TO, 0, 0, 0, 64'h11223344AAAAAAAA);
    core_req(0, STAT, 0, 0, 0, 64'h1_0003);
    core_req(1, TO, 64'h0, 8'h00, 0, 0);
    chk("wstrb0_noop", tohost, 64'h11223344AAAAAAAA);
    host_ack = 1;
    tick();
    host_ack = 0;
    // Decode errors leave state untouched
    core_req(0, 12'h004, 0, 0, 1, 0);
    core_req(1, STAT, 64'hFFFF, 8'hFF, 1, 0);
    core_req(1, 12'h001, 64'h77, 8'hFF, 1, 0);
    core_req(0, 12'h018, 0, 0, 1, 0);
    chk("err_tohost", tohost, 64'd0);
    core_req(0, STAT, 0, 0, 0, 64'h4);
    // Fromhost host writes and core clear
    chk("fh_wready_idle", {63'd0, fromhost_wready}, 64'd1);
    fromhost_wvalid = 1; fromhost_wdata = 64'hAB;
    tick();
    fromhost_wvalid = 0;
    chk("fh_busy", {63'd0, fromhost_busy}, 64'd1);
    chk("fh_wready_busy", {63'd0, fromhost_wready}, 64'd0);
    fromhost_wvalid = 1; fromhost_wdata = 64'hCD;
    tick();
    fromhost_wvalid = 0;
    core_req(0, FROM, 0, 0, 0, 64'hAB);
    fromhost_wvalid = 1; fromhost_wdata = 64'hEF;
    core_req(1, FROM, 64'h0, 8'h01, 0, 0);
    chk("fh_cleared", {63'd0, fromhost_busy}, 64'd0);
    chk("fh_wready_again", {63'd0, fromhost_wready}, 64'd1);
    fromhost_wvalid = 1; fromhost_wdata = 64'hEF;
    core_req(1, FROM, 64'h55, 8'hFF, 0, 0);
    core_req(0, FROM, 0, 0, 0, 64'h55);
    core_req(1, FROM, 64'h0, 8'hFF, 0, 0);
    // Response back-pressure
    core_req(1, TO, 64'h42, 8'hFF, 0, 0);
    resp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = TO;
    exp_q.push_back({1'b0, 64'h42});
    tick();
    req_valid = 0;
    host_ack = 1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, 64'h42);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
      host_ack = 0;
    end
    chk("ack_during_hold", tohost, 64'd0);
    resp_ready = 1;
    tick();
    chk("release_req_ready", {63'd0, req_ready}, 64'd1);
    chk("release_valid", {63'd0, resp_valid}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
